// File: rtl/led_trail_pwm.sv
// Comet-tail LED driver: one brightness register per LED, reloaded by the head,
// decayed on each step tick and rendered through a shared free-running PWM counter.
module led_trail_lane #(
  parameter int BRIGHT_W = 4,
  parameter int DECAY    = 4
) (
  input  logic                gclk,
  input  logic                grst_n,
  input  logic                i_step,
  input  logic                i_head,
  input  logic                i_en,
  input  logic [BRIGHT_W-1:0] i_pwm_cnt,
  output logic                o_led
);
  localparam logic [BRIGHT_W-1:0] BMAX = '1;
  localparam logic [BRIGHT_W-1:0] DEC  = BRIGHT_W'(DECAY);

  logic [BRIGHT_W-1:0] r_b;
  logic                r_led;
  logic [BRIGHT_W-1:0] w_b_dec;

  // Saturating decay: never wraps below zero.
  assign w_b_dec = (r_b >= DEC) ? (r_b - DEC) : '0;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      r_b   <= '0;
      r_led <= 1'b0;
    end else begin
      // Compare uses pre-edge brightness, so a new level shows one edge later.
      r_led <= i_en & (i_pwm_cnt < r_b);
      if (i_step) r_b <= i_head ? BMAX : w_b_dec;
    end
  end

  assign o_led = r_led;
endmodule

module led_trail_pwm #(
  parameter int NUM_LEDS = 10,
  parameter int BRIGHT_W = 4,
  parameter int DECAY    = 4
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic                step_tick,
  input  logic [NUM_LEDS-1:0] pos_onehot,
  input  logic                enable,
  output logic [NUM_LEDS-1:0] LEDR,
  output logic                err_multi
);
  localparam logic [BRIGHT_W-1:0] PWM_LAST = BRIGHT_W'((1 << BRIGHT_W) - 2);

  logic [BRIGHT_W-1:0] r_pwm_cnt;
  logic                r_err_multi;
  logic                w_multi;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi = |(pos_onehot & (pos_onehot - NUM_LEDS'(1)));

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt   <= '0;
      r_err_multi <= 1'b0;
    end else begin
      r_pwm_cnt <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;
      if (step_tick && w_multi) r_err_multi <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_lane
      led_trail_lane #(
        .BRIGHT_W (BRIGHT_W),
        .DECAY    (DECAY)
      ) u_lane (
        .gclk      (CLOCK_50),
        .grst_n    (reset_n),
        .i_step    (step_tick),
        .i_head    (pos_onehot[gi]),
        .i_en      (enable),
        .i_pwm_cnt (r_pwm_cnt),
        .o_led     (LEDR[gi])
      );
    end
  endgenerate

  assign err_multi = r_err_multi;
endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: duty-cycle table after each tick, hand-written reset and
// blanking sequences, then random stimulus against an arithmetic reference model.
module tb_led_trail_pwm;
  localparam int N    = 10;
  localparam int BW   = 4;
  localparam int DEC  = 4;
  localparam int BMAX = 15;

  logic         CLOCK_50   = 1'b0;
  logic         reset_n    = 1'b0;
  logic         step_tick  = 1'b0;
  logic [N-1:0] pos_onehot = '0;
  logic         enable     = 1'b1;
  logic [N-1:0] LEDR;
  logic         err_multi;

  int vecs = 0;
  int errs = 0;

  led_trail_pwm #(.NUM_LEDS(N), .BRIGHT_W(BW), .DECAY(DEC)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .step_tick  (step_tick),
    .pos_onehot (pos_onehot),
    .enable     (enable),
    .LEDR       (LEDR),
    .err_multi  (err_multi)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference model: plain integer brightness, max(b-DECAY,0), period-15 PWM phase.
  int           mb [N];
  int           mpwm;
  logic [N-1:0] mled;
  logic         merr;

  always @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) mb[i] <= 0;
      mpwm <= 0;
      mled <= '0;
      merr <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        mled[i] <= enable && (mpwm < mb[i]);
        if (step_tick) mb[i] <= pos_onehot[i] ? BMAX : ((mb[i] - DEC > 0) ? mb[i] - DEC : 0);
      end
      mpwm <= (mpwm + 1) % BMAX;
      if (step_tick && $countones(pos_onehot) > 1) merr <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic [N-1:0] p);
    step_tick  = 1'b1;
    pos_onehot = p;
    @(posedge CLOCK_50);
    #1;
    step_tick  = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]   pos;
    logic [4*N-1:0] duty;  // expected on-cycles per 15-cycle window, LED9 in top nibble
    logic           err;
  } vec_t;

  vec_t tbl[9];
  int   cnt[N];

  initial begin
    tbl[0] = '{pos: 10'h001, duty: 40'h000000000F, err: 1'b0};
    tbl[1] = '{pos: 10'h002, duty: 40'h00000000FB, err: 1'b0};
    tbl[2] = '{pos: 10'h004, duty: 40'h0000000FB7, err: 1'b0};
    tbl[3] = '{pos: 10'h000, duty: 40'h0000000B73, err: 1'b0};
    tbl[4] = '{pos: 10'h000, duty: 40'h0000000730, err: 1'b0};
    tbl[5] = '{pos: 10'h000, duty: 40'h0000000300, err: 1'b0};
    tbl[6] = '{pos: 10'h000, duty: 40'h0000000000, err: 1'b0};
    tbl[7] = '{pos: 10'h201, duty: 40'hF00000000F, err: 1'b1};
    tbl[8] = '{pos: 10'h100, duty: 40'hBF0000000B, err: 1'b1};

    #12;
    chk("reset_ledr", 32'(LEDR), 32'h0);
    chk("reset_err", 32'(err_multi), 32'h0);
    #11 reset_n = 1'b1;
    @(posedge CLOCK_50); #1;

    // Each tick followed by one full PWM period: on-count equals brightness.
    for (int k = 0; k < 9; k++) begin
      tick(tbl[k].pos);
      for (int i = 0; i < N; i++) cnt[i] = 0;
      repeat (BMAX) begin
        @(posedge CLOCK_50); #1;
        for (int i = 0; i < N; i++) cnt[i] += int'(LEDR[i]);
        if (pos_onehot !== tbl[k].pos) pos_onehot = ~pos_onehot;  // changes without a tick are ignored
      end
      for (int i = 0; i < N; i++)
        chk($sformatf("duty_v%0d_led%0d", k, i), 32'(cnt[i]), 32'(tbl[k].duty[4*i +: 4]));
      chk($sformatf("err_v%0d", k), 32'(err_multi), 32'(tbl[k].err));
      chk($sformatf("model_v%0d", k), 32'(LEDR), 32'(mled));
    end

    // Asynchronous reset between edges with LED5 lit and err set.
    tick(10'h020);
    repeat (7) @(posedge CLOCK_50);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_ledr", 32'(LEDR), 32'h0);
    chk("async_rst_err", 32'(err_multi), 32'h0);
    @(posedge CLOCK_50); #3 reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLOCK_50); #1;
      chk("post_rst_dark", 32'(LEDR), 32'h0);
    end

    // Blanking while the trail keeps evolving, then immediate restore.
    enable = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step_tick  = (c % 5 == 0);
      pos_onehot = N'(1) << ((c / 5) % N);
      @(posedge CLOCK_50); #1;
      step_tick = 1'b0;
      chk("blank", 32'(LEDR), 32'h0);
    end
    enable = 1'b1;
    for (int c = 0; c < BMAX; c++) begin
      @(posedge CLOCK_50); #1;
      chk("reenable", 32'(LEDR), 32'(mled));
    end

    // Random stimulus against the model.
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = int'($urandom_range(15, 0));
      step_tick = ($urandom_range(3, 0) == 0);
      if (r == 0)      pos_onehot = '0;
      else if (r == 1) pos_onehot = N'($urandom);
      else             pos_onehot = N'(1) << $urandom_range(N - 1, 0);
      if ($urandom_range(39, 0) == 0) enable = ~enable;
      if (c == 750) begin
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
      @(posedge CLOCK_50); #1;
      chk("rand_ledr", 32'(LEDR), 32'(mled));
      chk("rand_err", 32'(err_multi), 32'(merr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
